battleship_game_ctrl: RTL
=========================

BATTLESHIP_GAME_CTRL -- requirements
Module: battleship_game_ctrl

Interface
REQ-001 Parameter GRID_N, default 9: board edge length in cells (GRID_N x GRID_N per player), range 4..15.
REQ-002 Parameter NUM_SHIPS, default 4: ships per player.
REQ-003 Parameter SHIP_LEN, default 3: cells per ship, 2 <= SHIP_LEN <= GRID_N.
REQ-004 Derived widths: RW = $clog2(GRID_N); CW = $clog2(NUM_SHIPS*SHIP_LEN+1).
REQ-005 Clock and reset: one clock `clk`; reset `reset` is synchronous and active-high.
REQ-006 clk  in  1  system clock; all logic on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 cmd_valid  in  1  command request.
REQ-009 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
REQ-010 cmd_fire  in  1  0 = place ship, 1 = fire shot.
REQ-011 cmd_row, cmd_col  in  RW each  target cell; for placement, the ship origin.
REQ-012 cmd_vert  in  1  placement orientation: 0 = extends +col, 1 = extends +row.
REQ-013 rd_player  in  1  display read port: board select.
REQ-014 rd_row, rd_col  in  RW each  display read address.
REQ-015 rd_cell  out  2  cell state: 00 EMPTY, 01 SHIP, 10 MISS, 11 HIT.
REQ-016 phase  out  3  0 PLACE_P1, 1 PLACE_P2, 2 TURN_P1, 3 TURN_P2, 4 GAME_OVER.
REQ-017 resp_valid  out  1  one-cycle response pulse per accepted command.
REQ-018 resp_code  out  2  00 PLACED, 01 MISS, 10 HIT, 11 REJECTED; valid only with resp_valid.
REQ-019 winner  out  1  winning player (0 = P1); meaningful only in GAME_OVER.
REQ-020 remain_p1, remain_p2  out  CW each  unhit ship cells per player.

Function
REQ-021 Each board has one write port and one display read port; rd_cell is registered with 1-cycle latency; a same-cycle write to the read address returns the old value.
REQ-022 cmd_ready is 1 only when no command is in progress; it is 0 from acceptance until the cycle after resp_valid.
REQ-023 Placement in PLACE_Pn writes board n: if the ship exceeds the board (origin + SHIP_LEN > GRID_N on the extent axis), resp REJECTED at acceptance cycle t+1.
REQ-024 Otherwise, CHECK reads SHIP_LEN cells, one per cycle; any non-EMPTY cell causes REJECTED at t+SHIP_LEN+1, with no board write.
REQ-025 Otherwise, WRITE stores SHIP in SHIP_LEN cells, one per cycle, then PLACED at t+2*SHIP_LEN+1.
REQ-026 The NUM_SHIPS-th successful placement advances the phase PLACE_P1->PLACE_P2->TURN_P1 in the cycle of its resp_valid.
REQ-027 A fire in TURN_Pn targets the opponent's board: read at t+1, write and response at t+2.
REQ-028 Fire on SHIP: cell->HIT, that player's remain decrements, resp HIT; fire on EMPTY: cell->MISS, resp MISS; both then pass the turn.
REQ-029 Fire on a MISS/HIT cell: resp REJECTED, no write, turn unchanged.
REQ-030 A hit that drives the target's remain to 0 enters GAME_OVER, with winner = shooter, in the response cycle; resp is HIT.
REQ-031 A fire in a PLACE phase, a placement in a TURN phase, and any command in GAME_OVER give REJECTED at t+1, with no state change.
REQ-032 Rejected commands never alter phase, boards, counters or ship count.

Reset
REQ-033 On reset, boards clear to EMPTY (may take GRID_N*GRID_N cycles, with cmd_ready=0 until done), phase=PLACE_P1, remain_p1=remain_p2=NUM_SHIPS*SHIP_LEN, winner=0, resp_valid=0, ship counters=0.
REQ-034 Reset asserted mid-command aborts that command with no response and restarts the clear sequence.

Configuration
REQ-035 Macro BATTLESHIP_EXTRA_TURN_EN: when defined, a HIT (not game-ending) keeps the turn with the shooter. When undefined, every MISS or HIT alternates the turn.

Verification
REQ-036 Reset, place P1 at (0,0) horizontal -> PLACED at t+7 (SHIP_LEN=3); rd_cell of P1 (0,1) = 01.
REQ-037 Place at (0,7) horizontal with GRID_N=9 -> REJECTED at t+1; place overlapping (0,2) vertical -> REJECTED at t+4, board unchanged.
REQ-038 After 4+4 placements, phase=2; P1 fires on a P2 ship cell -> HIT at t+2, remain_p2=11, phase=3 (macro undefined) or 2 (macro defined).
REQ-039 Re-fire on the same cell -> REJECTED, phase unchanged; fire on an empty cell -> MISS, rd_cell = 10.
REQ-040 P1 hits all 12 P2 cells -> last resp HIT, phase=4, winner=0; subsequent command -> REJECTED.
REQ-041 Assert reset during a CHECK cycle -> no resp_valid; after the clear completes, phase=0, all cells 00, remain=12.

Source files
------------

// File: rtl/battleship_game_ctrl.sv
// battleship_game_ctrl: two-player battleship referee (define BATTLESHIP_EXTRA_TURN_EN to let a non-final hit keep the turn)
module battleship_game_ctrl #(
  parameter int GRID_N = 9,
  parameter int NUM_SHIPS = 4,
  parameter int SHIP_LEN = 3,
  localparam int RW = $clog2(GRID_N),
  localparam int CW = $clog2(NUM_SHIPS * SHIP_LEN + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_fire,
  input  logic [RW-1:0] cmd_row,
  input  logic [RW-1:0] cmd_col,
  input  logic          cmd_vert,
  input  logic          rd_player,
  input  logic [RW-1:0] rd_row,
  input  logic [RW-1:0] rd_col,
  output logic [1:0]    rd_cell,
  output logic [2:0]    phase,
  output logic          resp_valid,
  output logic [1:0]    resp_code,
  output logic          winner,
  output logic [CW-1:0] remain_p1,
  output logic [CW-1:0] remain_p2
);
`ifdef BATTLESHIP_EXTRA_TURN_EN
  localparam bit EXTRA_TURN = 1'b1;
`else
  localparam bit EXTRA_TURN = 1'b0;
`endif
  localparam int CELLS = GRID_N * GRID_N;
  localparam int AW = $clog2(CELLS);
  localparam int IW = $clog2(SHIP_LEN);
  localparam int SW = $clog2(NUM_SHIPS + 1);
  localparam logic [CW-1:0] TOTAL = CW'(NUM_SHIPS * SHIP_LEN);
  localparam logic [RW:0] GN = (RW + 1)'(GRID_N);
  localparam logic [RW:0] SL = (RW + 1)'(SHIP_LEN);

  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_CHECK, S_WRITE, S_FIRE, S_RESP} state_t;

  state_t state, state_nx;
  logic [1:0] board [2][CELLS];
  logic [AW-1:0] clr_idx, cell_addr, rd_addr, waddr;
  logic [RW-1:0] cur_row, cur_col, cell_r, cell_c;
  logic cur_vert, cur_player, conflict;
  logic [IW-1:0] idx;
  logic [SW-1:0] ships;
  logic [CW-1:0] remain [2];
  logic [1:0] cell_val, wdata, we;
  logic is_place, bad_coord, oob, reject, last_idx, conflict_any, rd_ok;

  assign remain_p1 = remain[0];
  assign remain_p2 = remain[1];

  // command decode and the cell currently addressed by a multi-cycle command
  always_comb begin
    is_place = phase[2:1] == 2'b00;
    bad_coord = {1'b0, cmd_row} >= GN || {1'b0, cmd_col} >= GN;
    oob = bad_coord || ({1'b0, cmd_vert ? cmd_row : cmd_col} + SL > GN);
    reject = phase == 3'd4 || (is_place ? (cmd_fire || oob) : (!cmd_fire || bad_coord));
    cell_r = cur_row + (cur_vert ? RW'(idx) : '0);
    cell_c = cur_col + (cur_vert ? '0 : RW'(idx));
    cell_addr = AW'(cell_r) * AW'(GRID_N) + AW'(cell_c);
    cell_val = board[cur_player][cell_addr];
    last_idx = idx == IW'(SHIP_LEN - 1);
    conflict_any = conflict || cell_val != 2'b00;
    rd_ok = {1'b0, rd_row} < GN && {1'b0, rd_col} < GN;
    rd_addr = AW'(rd_row) * AW'(GRID_N) + AW'(rd_col);
  end

  // state register; reset always restarts the board clear
  always_ff @(posedge clk) state <= reset ? S_CLEAR : state_nx;

  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_CLEAR: state_nx = clr_idx == AW'(CELLS - 1) ? S_IDLE : S_CLEAR;
      S_IDLE:  state_nx = !cmd_valid ? S_IDLE : reject ? S_RESP : is_place ? S_CHECK : S_FIRE;
      S_CHECK: state_nx = !last_idx ? S_CHECK : conflict_any ? S_RESP : S_WRITE;
      S_WRITE: state_nx = last_idx ? S_RESP : S_WRITE;
      S_FIRE:  state_nx = S_RESP;
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_CLEAR;
    endcase
  end

  // handshake, response strobe and board write port; a shot turns SHIP into HIT and EMPTY into MISS
  always_comb begin
    cmd_ready = state == S_IDLE;
    resp_valid = state == S_RESP;
    we = 2'b00;
    waddr = state == S_CLEAR ? clr_idx : cell_addr;
    wdata = state == S_CLEAR ? 2'b00 : state == S_FIRE ? {1'b1, cell_val[0]} : 2'b01;
    if (state == S_CLEAR) we = 2'b11;
    else if (state == S_WRITE || (state == S_FIRE && !cell_val[1])) we[cur_player] = 1'b1;
  end

  // board storage, one write port per player
  always_ff @(posedge clk) begin
    if (we[0] && !reset) board[0][waddr] <= wdata;
    if (we[1] && !reset) board[1][waddr] <= wdata;
  end

  // registered display read; a same-cycle write is seen one cycle later
  always_ff @(posedge clk) rd_cell <= reset ? 2'b00 : rd_ok ? board[rd_player][rd_addr] : 2'b00;

  // game bookkeeping: command capture, placement sweep, shot resolution
  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= 3'd0;
      winner <= 1'b0;
      remain[0] <= TOTAL;
      remain[1] <= TOTAL;
      ships <= '0;
      clr_idx <= '0;
      idx <= '0;
      conflict <= 1'b0;
      resp_code <= 2'b00;
      cur_row <= '0;
      cur_col <= '0;
      cur_vert <= 1'b0;
      cur_player <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: clr_idx <= clr_idx + 1'b1;
        S_IDLE: if (cmd_valid) begin
          cur_row <= cmd_row;
          cur_col <= cmd_col;
          cur_vert <= cmd_vert;
          cur_player <= is_place ? phase[0] : ~phase[0];
          idx <= '0;
          conflict <= 1'b0;
          resp_code <= 2'b11;
        end
        S_CHECK: begin
          idx <= last_idx ? '0 : idx + 1'b1;
          conflict <= conflict_any;
        end
        S_WRITE: begin
          idx <= idx + 1'b1;
          if (last_idx) begin
            resp_code <= 2'b00;
            ships <= ships == SW'(NUM_SHIPS - 1) ? '0 : ships + 1'b1;
            if (ships == SW'(NUM_SHIPS - 1)) phase <= phase + 3'd1;
          end
        end
        S_FIRE: if (!cell_val[1]) begin
          resp_code <= {cell_val[0], ~cell_val[0]};
          if (cell_val[0]) remain[cur_player] <= remain[cur_player] - 1'b1;
          if (cell_val[0] && remain[cur_player] == CW'(1)) begin
            phase <= 3'd4;
            winner <= ~cur_player;
          end else if (!(cell_val[0] && EXTRA_TURN)) phase <= {2'b01, ~phase[0]};
        end
        default: ;
      endcase
    end
  end
endmodule
